// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a 16-bit word out on mosi, MSB first, and
// captures 16 bits from miso in the same frame. A one-cycle start pulse
// launches a frame and a one-cycle done pulse ends it.
module spi_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] div_cnt, div_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [15:0]   tx_sr, tx_sr_nxt;
    logic [15:0]   rx_sr, rx_sr_nxt;
    logic [15:0]   rx_data_nxt;
    logic          cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic          div_last;
    logic          accept;

    assign div_last = (div_cnt == DIV_LAST);
    // A start coinciding with the done pulse is dropped; the earliest
    // accepted start is the cycle after done.
    assign accept   = (state == IDLE) && start && !done;

    // State register plus every registered output and datapath register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift registers are cleared too, so a frame aborted by
            // reset can never leak partially captured bits into a later frame.
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this edge, independent of order.
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            rx_data <= rx_data_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic: each timed state lasts exactly CLK_DIV cycles.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept)   state_nxt = SETUP;
            SETUP: if (div_last) state_nxt = HIGH;
            HIGH:  if (div_last) state_nxt = (bit_cnt == 4'd15) ? HOLD : LOW;
            LOW:   if (div_last) state_nxt = HIGH;
            HOLD:  if (div_last) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case below can infer a latch.
        cs_nxt      = cs;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rx_data_nxt = rx_data;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        bit_nxt     = bit_cnt;
        div_nxt     = (state == IDLE || state_nxt != state) ? '0 : div_cnt + CW'(1);

        unique case (state)
            IDLE: begin
                if (accept) begin
                    tx_sr_nxt = tx_data;
                    cs_nxt    = 1'b0;
                    mosi_nxt  = tx_data[15];
                    busy_nxt  = 1'b1;
                    bit_nxt   = 4'd0;
                end
            end
            SETUP, LOW: begin
                // Rising sclk edge: miso is sampled on this same clk edge.
                if (div_last) begin
                    sclk_nxt  = 1'b1;
                    rx_sr_nxt = {rx_sr[14:0], miso};
                end
            end
            HIGH: begin
                if (div_last) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt != 4'd15) begin
                        mosi_nxt  = tx_sr[14];
                        tx_sr_nxt = {tx_sr[14:0], 1'b0};
                        bit_nxt   = bit_cnt + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    cs_nxt      = 1'b1;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    rx_data_nxt = rx_sr;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (CLK_DIV=4). A cycle-level model derives
// every output from the frame's start cycle by arithmetic on the phase offset;
// a slave model on the SPI pins supplies miso and decodes mosi.
module tb_spi_master;

    localparam int D     = 4;
    localparam int FRAME = 33 * D;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] tx_data;
    logic        busy, done, sclk, mosi, miso, cs;
    logic [15:0] rx_data;

    spi_master #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs      (cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave side: miso from slave_word (changed on falling sclk), mosi decoded on rising sclk.
    logic        loopback   = 1'b1;
    logic [15:0] slave_word = '0;
    logic [15:0] slave_rx   = '0;
    logic        slave_miso = 1'b0;
    int          sidx       = 15;

    assign miso = loopback ? mosi : slave_miso;

    always @(negedge cs) begin
        sidx       = 15;
        slave_miso = slave_word[15];
        slave_rx   = '0;
    end

    always @(negedge sclk) begin
        if (!cs && sidx > 0) begin
            sidx--;
            slave_miso = slave_word[sidx];
        end
    end

    always @(posedge sclk) slave_rx = {slave_rx[14:0], mosi};

    // Behavioural model: frame outputs as a function of k = cycles since start.
    bit          m_valid = 0;
    bit          m_in    = 0;
    int          m_t0    = 0;
    int          m_done  = -1;
    logic [15:0] m_tx    = '0;
    logic [15:0] m_rxw   = '0;
    logic [15:0] m_rx_hold = '0;
    logic        m_mosi_hold = 1'b0;

    // Per-cycle compare, then advance the model to the next cycle.
    always @(negedge clk) begin
        int   j;
        logic e_cs, e_sclk, e_mosi, e_busy;
        if (m_valid) begin
            if (m_in) begin
                j      = cyc - m_t0 - 1;
                e_cs   = 1'b0;
                e_busy = 1'b1;
                e_sclk = (j >= D) && (j < 32 * D) && (((j - D) % (2 * D)) < D);
                e_mosi = (j < 32 * D) ? m_tx[15 - j / (2 * D)] : m_tx[0];
            end else begin
                e_cs   = 1'b1;
                e_busy = 1'b0;
                e_sclk = 1'b0;
                e_mosi = m_mosi_hold;
            end
            check("cs",      cs,      e_cs);
            check("sclk",    sclk,    e_sclk);
            check("mosi",    mosi,    e_mosi);
            check("busy",    busy,    e_busy);
            check("done",    done,    cyc == m_done);
            check("rx_data", rx_data, m_rx_hold);
        end
        if (reset) begin
            m_valid     = 1;
            m_in        = 0;
            m_rx_hold   = '0;
            m_mosi_hold = 1'b0;
            m_done      = -1;
        end else if (m_valid) begin
            if (m_in) begin
                if (cyc + 1 - m_t0 == FRAME + 1) begin
                    m_in        = 0;
                    m_rx_hold   = m_rxw;
                    m_mosi_hold = m_tx[0];
                    m_done      = cyc + 1;
                end
            end else if (start && cyc != m_done) begin
                m_in  = 1;
                m_t0  = cyc;
                m_tx  = tx_data;
                m_rxw = loopback ? tx_data : slave_word;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; tx_data is scrambled afterwards since it must not matter.
    task automatic pulse_start(input logic [15:0] d);
        tx_data = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tx_data = 16'($urandom);
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < FRAME + 20) begin
            tick();
            n++;
        end
        check("frame done within budget", done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, lows, rises;
        logic        prev;
        logic [15:0] w, exp_rx;
        int          gap, dly;

        reset   = 1'b1;
        start   = 1'b0;
        tx_data = '0;
        repeat (3) tick();
        check("reset cs",      cs,      1'b1);
        check("reset sclk",    sclk,    1'b0);
        check("reset mosi",    mosi,    1'b0);
        check("reset busy",    busy,    1'b0);
        check("reset done",    done,    1'b0);
        check("reset rx_data", rx_data, 16'h0000);
        reset = 1'b0;
        tick();

        // Loopback frame 0x1234 with literal timing expectations.
        pulse_start(16'h1234);
        k = 1; lows = 0; rises = 0; prev = 1'b0;
        while (!done && k < 300) begin
            if (!cs) lows++;
            if (sclk && !prev) rises++;
            prev = sclk;
            tick();
            k++;
        end
        check("done offset",     16'(k),     16'd133);
        check("cs low cycles",   16'(lows),  16'd132);
        check("sclk rises",      16'(rises), 16'd16);
        check("loopback rx",     rx_data,    16'h1234);
        check("mosi decode",     slave_rx,   16'h1234);
        tick();

        // Slave drives 0xA5C3 while master sends 9999.
        loopback   = 1'b0;
        slave_word = 16'hA5C3;
        tick();
        pulse_start(16'h270F);
        wait_done();
        check("slave rx",        rx_data,  16'hA5C3);
        check("slave decode",    slave_rx, 16'h270F);
        // Start in the done cycle is dropped.
        pulse_start(16'hBEEF);
        check("start with done ignored", busy, 1'b0);
        tick();

        // Start re-pulsed mid-frame is ignored; exactly one done.
        loopback = 1'b1;
        tick();
        pulse_start(16'h0001);
        repeat (40) tick();
        pulse_start(16'hFFFF);
        wait_done();
        check("repulse rx", rx_data, 16'h0001);
        k = 0;
        repeat (150) begin
            tick();
            if (done) k++;
        end
        check("extra done pulses", 16'(k), 16'd0);

        // Reset while the bit counter is 7 (inside the high phase of bit 7).
        pulse_start(16'hABCD);
        repeat (15 * D + 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort cs",      cs,      1'b1);
        check("abort sclk",    sclk,    1'b0);
        check("abort done",    done,    1'b0);
        check("abort rx_data", rx_data, 16'h0000);
        repeat (5) tick();
        pulse_start(16'h00FF);
        wait_done();
        check("after abort rx", rx_data, 16'h00FF);
        tick();

        // Back-to-back frames with start in the cycle after done.
        pulse_start(16'h8000);
        wait_done();
        check("b2b first rx", rx_data, 16'h8000);
        tick();
        check("b2b gap cs high", cs, 1'b1);
        pulse_start(16'h0001);
        check("b2b cs low again", cs, 1'b0);
        wait_done();
        check("b2b second rx", rx_data, 16'h0001);

        // Randomized frames: loopback or slave data, stray mid-frame starts.
        repeat (8) begin
            gap = $urandom_range(1, 3);
            repeat (gap) tick();
            loopback   = 1'($urandom);
            slave_word = 16'($urandom);
            w          = 16'($urandom);
            exp_rx     = loopback ? w : slave_word;
            pulse_start(w);
            dly = $urandom_range(1, 120);
            repeat (dly) tick();
            pulse_start(16'($urandom));
            wait_done();
            check("random rx",     rx_data,  exp_rx);
            check("random decode", slave_rx, w);
        end
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
